// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader: state encoding, byte width and
// the default load address.
package prog_loader_pkg;

  localparam int         LD_BYTE_W     = 8;
  localparam logic [7:0] LD_START_ADDR = 8'h00;

  typedef enum logic [2:0] {
    LD_IDLE = 3'd0,
    LD_LEN  = 3'd1,
    LD_DATA = 3'd2,
    LD_CSUM = 3'd3,
    LD_RUN  = 3'd4,
    LD_DONE = 3'd5,
    LD_ERR  = 3'd6
  } ld_state_t;

  // States in which a load is considered in progress (start is ignored).
  function automatic logic ld_is_busy(input ld_state_t s);
    return (s == LD_LEN) || (s == LD_DATA) || (s == LD_CSUM) || (s == LD_RUN);
  endfunction

  // States in which the loader accepts an upstream byte.
  function automatic logic ld_takes_byte(input ld_state_t s);
    return (s == LD_LEN) || (s == LD_DATA) || (s == LD_CSUM);
  endfunction

endpackage

// File: rtl/ld_byte_ctr.sv
// Loader datapath: remaining-byte counter, RAM address pointer and running
// modulo-2^DATA_W checksum of the payload.
module ld_byte_ctr
  import prog_loader_pkg::*;
#(
  parameter int                ADDR_W     = 8,
  parameter int                DATA_W     = LD_BYTE_W,
  parameter logic [ADDR_W-1:0] START_ADDR = ADDR_W'(LD_START_ADDR)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init,
  input  logic              load_cnt,
  input  logic              step,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] count,
  output logic [ADDR_W-1:0] ptr,
  output logic [DATA_W-1:0] sum
);

  logic [DATA_W-1:0] count_reg;
  logic [ADDR_W-1:0] ptr_reg;
  logic [DATA_W-1:0] sum_reg;

  // init restarts pointer and checksum; load_cnt takes the length byte;
  // step consumes one payload byte (pointer wraps naturally at 2^ADDR_W).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg <= '0;
      ptr_reg   <= START_ADDR;
      sum_reg   <= '0;
    end else begin
      if (init) begin
        ptr_reg <= START_ADDR;
        sum_reg <= '0;
      end else if (step) begin
        ptr_reg <= ptr_reg + 1'b1;
        sum_reg <= sum_reg + din;
      end
      if (load_cnt) begin
        count_reg <= din;
      end else if (step) begin
        count_reg <= count_reg - 1'b1;
      end
    end
  end

  assign count = count_reg;
  assign ptr   = ptr_reg;
  assign sum   = sum_reg;

endmodule

// File: rtl/prog_loader.sv
// Byte-stream program loader: takes a length byte, N payload bytes and a
// checksum byte, writes the payload into CPU RAM and releases the CPU with a
// single run pulse when the checksum matches.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int                ADDR_W     = 8,
  parameter int                DATA_W     = LD_BYTE_W,
  parameter logic [ADDR_W-1:0] START_ADDR = ADDR_W'(LD_START_ADDR)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  output logic              cpu_halt,
  output logic              cpu_run,
  output logic              busy,
  output logic              done,
  output logic              err
);

  ld_state_t         state_reg;
  ld_state_t         state_next;
  logic              xfer;
  logic              ctr_init;
  logic              ctr_load;
  logic              ctr_step;
  logic              wren_next;
  logic [DATA_W-1:0] count;
  logic [ADDR_W-1:0] ptr;
  logic [DATA_W-1:0] sum;
  logic              wren_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] data_reg;

  assign in_ready = ld_takes_byte(state_reg);
  assign xfer     = in_valid & in_ready;

  ld_byte_ctr #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .START_ADDR(START_ADDR)
  ) u_ctr (
    .clk     (clk),
    .rst     (rst),
    .init    (ctr_init),
    .load_cnt(ctr_load),
    .step    (ctr_step),
    .din     (in_data),
    .count   (count),
    .ptr     (ptr),
    .sum     (sum)
  );

  // State register; reset aborts any load in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= LD_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and datapath controls.
  always_comb begin
    state_next = state_reg;
    ctr_init   = 1'b0;
    ctr_load   = 1'b0;
    ctr_step   = 1'b0;
    wren_next  = 1'b0;
    case (state_reg)
      LD_IDLE, LD_DONE, LD_ERR: begin
        if (start) begin
          state_next = LD_LEN;
          ctr_init   = 1'b1;
        end
      end
      LD_LEN: begin
        if (xfer) begin
          ctr_load   = 1'b1;
          state_next = (in_data != '0) ? LD_DATA : LD_CSUM;
        end
      end
      LD_DATA: begin
        if (xfer) begin
          ctr_step  = 1'b1;
          wren_next = 1'b1;
          if (count == DATA_W'(1)) begin
            state_next = LD_CSUM;
          end
        end
      end
      LD_CSUM: begin
        if (xfer) begin
          state_next = (in_data == sum) ? LD_RUN : LD_ERR;
        end
      end
      LD_RUN: begin
        state_next = LD_DONE;
      end
      default: begin
        state_next = LD_IDLE;
      end
    endcase
  end

  // RAM write port: one registered write per accepted payload byte; address
  // and data hold their last values between writes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wren_reg <= 1'b0;
      addr_reg <= START_ADDR;
      data_reg <= '0;
    end else begin
      wren_reg <= wren_next;
      if (wren_next) begin
        addr_reg <= ptr;
        data_reg <= in_data;
      end
    end
  end

  assign ram_wren = wren_reg;
  assign ram_addr = addr_reg;
  assign ram_data = data_reg;

  // CPU control and status decode directly from the state register so that
  // reset forces them at once. The CPU is released only in RUN/DONE.
  assign cpu_run  = (state_reg == LD_RUN);
  assign cpu_halt = !((state_reg == LD_RUN) || (state_reg == LD_DONE));
  assign busy     = ld_is_busy(state_reg);
  assign done     = (state_reg == LD_DONE);
  assign err      = (state_reg == LD_ERR);

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: two instances (load address 00 and FE)
// share the byte stream; a queue holds the expected RAM writes.
module tb_prog_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start0 = 1'b0;
  logic       start1 = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       sel = 1'b0;

  logic       rdy0, wren0, halt0, run0, busy0, done0, err0;
  logic [7:0] addr0, data0;
  logic       rdy1, wren1, halt1, run1, busy1, done1, err1;
  logic [7:0] addr1, data1;

  logic       rdy, wren, halt, run, busy, done, err;
  logic [7:0] waddr, wdata;

  int         tests = 0;
  int         fails = 0;
  logic [15:0] exp_q[$];
  logic [7:0]  pay_q[$];

  always #5 clk = ~clk;

  prog_loader #(.ADDR_W(8), .DATA_W(8), .START_ADDR(8'h00)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy0), .ram_addr(addr0), .ram_data(data0), .ram_wren(wren0),
    .cpu_halt(halt0), .cpu_run(run0), .busy(busy0), .done(done0), .err(err0)
  );

  prog_loader #(.ADDR_W(8), .DATA_W(8), .START_ADDR(8'hFE)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy1), .ram_addr(addr1), .ram_data(data1), .ram_wren(wren1),
    .cpu_halt(halt1), .cpu_run(run1), .busy(busy1), .done(done1), .err(err1)
  );

  assign rdy   = sel ? rdy1  : rdy0;
  assign wren  = sel ? wren1 : wren0;
  assign halt  = sel ? halt1 : halt0;
  assign run   = sel ? run1  : run0;
  assign busy  = sel ? busy1 : busy0;
  assign done  = sel ? done1 : done0;
  assign err   = sel ? err1  : err0;
  assign waddr = sel ? addr1 : addr0;
  assign wdata = sel ? data1 : data0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_start;
    if (sel) start1 = 1'b1; else start0 = 1'b1;
    tick;
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  // Offer one byte (after gap idle cycles) and check the write it causes.
  task automatic send(input logic [7:0] b, input bit payload, input logic [7:0] a, input int gap);
    int w;
    logic [15:0] e;
    for (int g = 0; g < gap; g++) begin
      in_valid = 1'b0;
      tick;
      chk("gap_wren", {31'd0, wren}, 32'd0);
    end
    in_valid = 1'b1;
    in_data  = b;
    w = 0;
    while (!rdy && w < 20) begin
      tick;
      w++;
    end
    if (!rdy) chk("ready_timeout", {31'd0, rdy}, 32'd1);
    if (payload) exp_q.push_back({a, b});
    tick;
    if (payload) begin
      e = exp_q.pop_front();
      chk("wren", {31'd0, wren}, 32'd1);
      chk("waddr", {24'd0, waddr}, {24'd0, e[15:8]});
      chk("wdata", {24'd0, wdata}, {24'd0, e[7:0]});
    end else begin
      chk("no_wren", {31'd0, wren}, 32'd0);
    end
  endtask

  // Full load of pay_q from base address with checksum cs.
  task automatic run_load(input logic [7:0] base, input logic [7:0] cs, input int gap, input bit mid_start);
    logic [7:0] a;
    logic [7:0] s;
    int n;
    n = pay_q.size();
    in_valid = 1'b0;
    pulse_start;
    chk("st_busy", {31'd0, busy}, 32'd1);
    chk("st_halt", {31'd0, halt}, 32'd1);
    chk("st_done", {31'd0, done}, 32'd0);
    chk("st_err", {31'd0, err}, 32'd0);
    chk("st_rdy", {31'd0, rdy}, 32'd1);
    send(8'(n), 1'b0, 8'h00, gap);
    a = base;
    s = 8'h00;
    for (int i = 0; i < n; i++) begin
      send(pay_q[i], 1'b1, a, gap);
      a = a + 8'd1;
      s = s + pay_q[i];
      if (mid_start && i == 0) begin
        in_valid = 1'b0;
        pulse_start;
        chk("mid_start_wren", {31'd0, wren}, 32'd0);
        chk("mid_start_busy", {31'd0, busy}, 32'd1);
      end
    end
    send(cs, 1'b0, 8'h00, gap);
    in_valid = 1'b0;
    if (cs == s) begin
      chk("run_pulse", {31'd0, run}, 32'd1);
      chk("run_halt", {31'd0, halt}, 32'd0);
      tick;
      chk("run_end", {31'd0, run}, 32'd0);
      chk("done", {31'd0, done}, 32'd1);
      chk("done_busy", {31'd0, busy}, 32'd0);
      chk("done_halt", {31'd0, halt}, 32'd0);
      chk("done_err", {31'd0, err}, 32'd0);
    end else begin
      chk("err", {31'd0, err}, 32'd1);
      chk("err_run", {31'd0, run}, 32'd0);
      chk("err_halt", {31'd0, halt}, 32'd1);
      chk("err_busy", {31'd0, busy}, 32'd0);
      tick;
      chk("err_hold", {31'd0, err}, 32'd1);
      chk("err_run2", {31'd0, run}, 32'd0);
      chk("err_done", {31'd0, done}, 32'd0);
    end
  endtask

  initial begin
    // Reset state
    tick;
    chk("rst_rdy", {31'd0, rdy0}, 32'd0);
    chk("rst_wren", {31'd0, wren0}, 32'd0);
    chk("rst_addr0", {24'd0, addr0}, 32'h00);
    chk("rst_addr1", {24'd0, addr1}, 32'hFE);
    chk("rst_data", {24'd0, data0}, 32'd0);
    chk("rst_halt", {31'd0, halt0}, 32'd1);
    chk("rst_run", {31'd0, run0}, 32'd0);
    chk("rst_busy", {31'd0, busy0}, 32'd0);
    chk("rst_done", {31'd0, done0}, 32'd0);
    chk("rst_err", {31'd0, err0}, 32'd0);
    rst = 1'b1;
    tick;
    $display("[TB] reset checked");

    // Good load of three bytes
    pay_q = '{8'h3F, 8'h05, 8'h00};
    run_load(8'h00, 8'h44, 0, 1'b0);
    $display("[TB] load 3F 05 00 / 44 complete");

    // Bytes offered in DONE are not consumed
    in_valid = 1'b1; in_data = 8'h99;
    chk("done_rdy", {31'd0, rdy}, 32'd0);
    tick;
    chk("done_stay", {31'd0, done}, 32'd1);
    in_valid = 1'b0;

    // Bad checksum (restart from DONE re-halts)
    pay_q = '{8'h10, 8'h20};
    run_load(8'h00, 8'h31, 0, 1'b0);
    $display("[TB] load 10 20 / 31 complete (checksum error)");

    // Empty image (restart from ERR)
    pay_q = {};
    run_load(8'h00, 8'h00, 0, 1'b0);
    $display("[TB] empty load complete");

    // Address wrap on the FE instance
    sel = 1'b1;
    pay_q = '{8'hAA, 8'hBB, 8'hCC};
    run_load(8'hFE, 8'h31, 0, 1'b0);
    chk("idle_dut0_wren", {31'd0, wren0}, 32'd0);
    $display("[TB] wrapping load AA BB CC / 31 complete");

    // Throttled stream with an ignored start pulse mid-DATA
    sel = 1'b0;
    pay_q = '{8'h01, 8'h02, 8'h03};
    run_load(8'h00, 8'h06, 2, 1'b1);
    $display("[TB] throttled load complete");

    // Asynchronous reset mid-DATA
    in_valid = 1'b0;
    pulse_start;
    send(8'h03, 1'b0, 8'h00, 0);
    send(8'h11, 1'b1, 8'h00, 0);
    in_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy0}, 32'd0);
    chk("arst_halt", {31'd0, halt0}, 32'd1);
    chk("arst_rdy", {31'd0, rdy0}, 32'd0);
    chk("arst_wren", {31'd0, wren0}, 32'd0);
    chk("arst_addr", {24'd0, addr0}, 32'h00);
    @(negedge clk);
    rst = 1'b1;
    tick;
    $display("[TB] async reset checked");

    pay_q = '{8'h77};
    run_load(8'h00, 8'h77, 0, 1'b0);
    $display("[TB] post-reset load complete");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

endmodule
